// File: rtl/logic_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive logic sweep controller.
package logic_sweep_pkg;

  localparam int DEF_N_IN  = 3;
  localparam int DEF_N_OUT = 2;
  localparam int DEF_DWELL = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } sweep_state_e;

  function automatic int TABLE_W(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction

  // A single-cycle dwell still needs a one-bit counter.
  function automatic int CNT_W(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/logic_sweep_dwell_cnt.sv
// Loadable settle down-counter; load wins over decrement and it saturates at zero.
module logic_sweep_dwell_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Steps an evaluator through every input vector, settles DWELL cycles, and packs its outputs into a truth table.
// Build with LOGIC_SWEEP_CHECK_EN to compare each entry against exp_table and flag the first mismatch.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 stop,
  output logic [N_IN-1:0]                      dut_in,
  input  logic [N_OUT-1:0]                     dut_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 res_wr,
  output logic [N_IN-1:0]                      res_addr,
  output logic [N_OUT-1:0]                     res_data,
`ifdef LOGIC_SWEEP_CHECK_EN
  input  logic [TABLE_W(N_IN, N_OUT)-1:0]      exp_table,
  output logic                                 mismatch,
  output logic [N_IN-1:0]                      fail_idx,
`endif
  output logic [TABLE_W(N_IN, N_OUT)-1:0]      table_o
);

  localparam int TW = TABLE_W(N_IN, N_OUT);
  localparam int CW = CNT_W(DWELL);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

  sweep_state_e r_state;
  sweep_state_e w_nxt;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_accept;
  logic w_capture;

  logic [N_IN-1:0]  r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_res_wr;
  logic [N_IN-1:0]  r_res_addr;
  logic [N_OUT-1:0] r_res_data;
  logic [TW-1:0]    r_table;

  logic_sweep_dwell_cnt #(
    .W(CW)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (LOAD_VAL),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // stop overrides everything outside IDLE, including the capture in SAMPLE.
  always_comb begin
    w_nxt     = r_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_nxt    = ST_SETTLE;
          w_load   = 1'b1;
          w_accept = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          w_nxt = ST_IDLE;
        end else if (w_zero) begin
          w_nxt = ST_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (stop) begin
          w_nxt = ST_IDLE;
        end else begin
          w_capture = 1'b1;
          if (&r_dut_in) begin
            w_nxt = ST_FIN;
          end else begin
            w_nxt  = ST_SETTLE;
            w_load = 1'b1;
          end
        end
      end
      ST_FIN: begin
        w_nxt = ST_IDLE;
      end
      default: begin
        w_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res_wr   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_table    <= '0;
    end else begin
      r_busy   <= (w_nxt == ST_SETTLE) || (w_nxt == ST_SAMPLE);
      r_done   <= (w_nxt == ST_FIN);
      r_res_wr <= w_capture;
      if (w_nxt == ST_IDLE) begin
        r_dut_in <= '0;
      end else if (w_capture && !(&r_dut_in)) begin
        r_dut_in <= r_dut_in + 1'b1;
      end
      if (w_accept) begin
        r_table <= '0;
      end else if (w_capture) begin
        r_table[int'(r_dut_in) * N_OUT +: N_OUT] <= dut_out;
        r_res_addr <= r_dut_in;
        r_res_data <= dut_out;
      end
    end
  end

`ifdef LOGIC_SWEEP_CHECK_EN
  logic            r_mismatch;
  logic [N_IN-1:0] r_fail_idx;
  logic            w_diff;

  assign w_diff = (dut_out != exp_table[int'(r_dut_in) * N_OUT +: N_OUT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_capture && w_diff && !r_mismatch) begin
      r_mismatch <= 1'b1;
      r_fail_idx <= r_dut_in;
    end
  end

  assign mismatch = r_mismatch;
  assign fail_idx = r_fail_idx;
`endif

  assign dut_in   = r_dut_in;
  assign busy     = r_busy;
  assign done     = r_done;
  assign res_wr   = r_res_wr;
  assign res_addr = r_res_addr;
  assign res_data = r_res_data;
  assign table_o  = r_table;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: a DWELL=4 and a DWELL=1 instance driven from a shared lookup-table evaluator.
module tb_logic_sweep_ctrl;

  localparam int NI = 3;
  localparam int NO = 2;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic stop;
  logic sel;
  logic [NO-1:0] lut [8];
  logic [TW-1:0] exp_table;

  int checks = 0;
  int errors = 0;

  logic [NI-1:0] dut_in_a, dut_in_b, res_addr_a, res_addr_b;
  logic [NO-1:0] dut_out_a, dut_out_b, res_data_a, res_data_b;
  logic busy_a, busy_b, done_a, done_b, res_wr_a, res_wr_b;
  logic [TW-1:0] table_a, table_b;
  logic mm_a, mm_b;
  logic [NI-1:0] fi_a, fi_b;

  assign dut_out_a = lut[dut_in_a];
  assign dut_out_b = lut[dut_in_b];

  logic start_a, start_b, stop_a, stop_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign stop_a  = stop & ~sel;
  assign stop_b  = stop & sel;

  logic          busy_s, done_s, res_wr_s;
  logic [NI-1:0] dut_in_s, res_addr_s;
  logic [NO-1:0] res_data_s;
  logic [TW-1:0] table_s;
  assign busy_s     = sel ? busy_b     : busy_a;
  assign done_s     = sel ? done_b     : done_a;
  assign res_wr_s   = sel ? res_wr_b   : res_wr_a;
  assign dut_in_s   = sel ? dut_in_b   : dut_in_a;
  assign res_addr_s = sel ? res_addr_b : res_addr_a;
  assign res_data_s = sel ? res_data_b : res_data_a;
  assign table_s    = sel ? table_b    : table_a;

`ifndef LOGIC_SWEEP_CHECK_EN
  assign mm_a = 1'b0;
  assign mm_b = 1'b0;
  assign fi_a = '0;
  assign fi_b = '0;
`endif

  logic_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .DWELL(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .stop      (stop_a),
    .dut_in    (dut_in_a),
    .dut_out   (dut_out_a),
    .busy      (busy_a),
    .done      (done_a),
    .res_wr    (res_wr_a),
    .res_addr  (res_addr_a),
    .res_data  (res_data_a),
`ifdef LOGIC_SWEEP_CHECK_EN
    .exp_table (exp_table),
    .mismatch  (mm_a),
    .fail_idx  (fi_a),
`endif
    .table_o   (table_a)
  );

  logic_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .DWELL(1)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .stop      (stop_b),
    .dut_in    (dut_in_b),
    .dut_out   (dut_out_b),
    .busy      (busy_b),
    .done      (done_b),
    .res_wr    (res_wr_b),
    .res_addr  (res_addr_b),
    .res_data  (res_data_b),
`ifdef LOGIC_SWEEP_CHECK_EN
    .exp_table (exp_table),
    .mismatch  (mm_b),
    .fail_idx  (fi_b),
`endif
    .table_o   (table_b)
  );

  // Reference: truth table holding the first n lookup entries, all others zero.
  function automatic logic [TW-1:0] model_table(input int n);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i*NO +: NO] = lut[i];
    return t;
  endfunction

  function automatic int dwell_of_sel();
    return sel ? 1 : 4;
  endfunction

  task automatic load_named_eval(input bit y_zero);
    for (int i = 0; i < 8; i++) begin
      logic a, b, c, x, y;
      a = i[0]; b = i[1]; c = i[2];
      x = (a & ~c) | ~(a | ~b) | (c & ~(c & ~a));
      y = y_zero ? 1'b0 : (a | b);
      lut[i] = {y, x};
    end
  endtask

  task automatic load_random_eval();
    for (int i = 0; i < 8; i++) lut[i] = NO'($urandom_range(0, 3));
  endtask

  // Full sweep from IDLE; optionally re-pulses start at cycle restart_at after acceptance.
  task automatic run_sweep(input string name, input int restart_at);
    int per, total, busy_n, done_n, wr_n, done_at, last_busy;
    per = dwell_of_sel() + 1;
    total = 8 * per;
    busy_n = 0; done_n = 0; wr_n = 0; done_at = -1; last_busy = -1;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < total + 6; c++) begin
      start = (c == restart_at);
      if (busy_s) begin
        busy_n++;
        last_busy = c;
      end
      if (c < total) begin
        checks++;
        if (dut_in_s !== 3'(c / per)) begin
          errors++;
          $display("FAIL %s dut_in cyc %0d: got %0d want %0d", name, c, dut_in_s, c / per);
        end
      end
      if (res_wr_s) begin
        checks++;
        if (wr_n >= 8) begin
          errors++;
          $display("FAIL %s extra res_wr at cyc %0d: got %0d strobes want 8", name, c, wr_n + 1);
        end else if (res_addr_s !== 3'(wr_n) || res_data_s !== lut[wr_n] || c != (wr_n + 1) * per) begin
          errors++;
          $display("FAIL %s res_wr %0d: got addr %0d data %0d cyc %0d want addr %0d data %0d cyc %0d",
                   name, wr_n, res_addr_s, res_data_s, c, wr_n, lut[wr_n], (wr_n + 1) * per);
        end
        wr_n++;
      end
      if (done_s) begin
        done_n++;
        done_at = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy_n != total || last_busy != total - 1) begin
      errors++;
      $display("FAIL %s busy: got %0d cycles last %0d want %0d last %0d", name, busy_n, last_busy, total, total - 1);
    end
    checks++;
    if (done_n != 1 || done_at != total) begin
      errors++;
      $display("FAIL %s done: got %0d pulses at %0d want 1 at %0d", name, done_n, done_at, total);
    end
    checks++;
    if (wr_n != 8) begin
      errors++;
      $display("FAIL %s res_wr count: got %0d want 8", name, wr_n);
    end
    checks++;
    if (table_s !== model_table(8)) begin
      errors++;
      $display("FAIL %s table_o: got %h want %h", name, table_s, model_table(8));
    end
    checks++;
    if (dut_in_s !== '0) begin
      errors++;
      $display("FAIL %s dut_in idle: got %0d want 0", name, dut_in_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sel = 1'b0;
    exp_table = 16'hFCFC;
    for (int i = 0; i < 8; i++) lut[i] = '0;
    #12;
    checks++;
    if ({busy_a, done_a, res_wr_a, res_addr_a, res_data_a, dut_in_a, table_a, mm_a, fi_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h/%h/%h want all 0", table_a, dut_in_a, {busy_a, done_a, res_wr_a});
    end
    checks++;
    if ({busy_b, done_b, res_wr_b, res_addr_b, res_data_b, dut_in_b, table_b, mm_b, fi_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h/%h/%h want all 0", table_b, dut_in_b, {busy_b, done_b, res_wr_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_named_eval();
    load_named_eval(1'b0);
    sel = 1'b0;
    run_sweep("named_d4", -1);
    checks++;
    if (table_a !== 16'hFCFC) begin
      errors++;
      $display("FAIL named_d4 const: got %h want fcfc", table_a);
    end
    sel = 1'b1;
    run_sweep("named_d1", -1);
    checks++;
    if (table_b !== 16'hFCFC) begin
      errors++;
      $display("FAIL named_d1 const: got %h want fcfc", table_b);
    end
  endtask

  task automatic test_random_eval();
    for (int n = 0; n < 4; n++) begin
      load_random_eval();
      sel = 1'($urandom_range(0, 1));
      run_sweep("random", -1);
    end
  endtask

  task automatic test_start_ignored();
    load_random_eval();
    sel = 1'b0;
    run_sweep("restart", 10);
  endtask

  // Stops during SETTLE of vector k; entries 0..k-1 must survive, the rest stay zero.
  task automatic test_stop(input string name, input int k, input bit s);
    int per, stop_at, stray;
    sel = s;
    per = dwell_of_sel() + 1;
    stop_at = k * per + $urandom_range(0, per - 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < stop_at; c++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || dut_in_s !== '0) begin
      errors++;
      $display("FAIL %s after stop: got busy %b done %b dut_in %0d want 0 0 0", name, busy_s, done_s, dut_in_s);
    end
    checks++;
    if (table_s !== model_table(k)) begin
      errors++;
      $display("FAIL %s partial table: got %h want %h", name, table_s, model_table(k));
    end
    stray = 0;
    for (int c = 0; c < 50; c++) begin
      if (busy_s || done_s || res_wr_s) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL %s quiet after stop: got %0d active cycles want 0", name, stray);
    end
  endtask

  task automatic test_stop_start_same_cycle();
    int act;
    sel = 1'b0;
    act = 0;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy_s || res_wr_s || done_s) act++;
      @(negedge clk);
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL stop_start: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_async_reset();
    load_random_eval();
    sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5 * 5 + 4; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, res_wr_a, res_addr_a, res_data_a, dut_in_a, table_a} !== '0) begin
      errors++;
      $display("FAIL async_reset: got table %h dut_in %0d busy %b want 0", table_a, dut_in_a, busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_random_eval();
    run_sweep("after_reset", -1);
  endtask

`ifdef LOGIC_SWEEP_CHECK_EN
  task automatic test_check();
    int first, seen;
    load_named_eval(1'b1);
    exp_table = 16'hFCFC;
    sel = 1'b0;
    first = -1;
    for (int i = 7; i >= 0; i--) if (lut[i] != exp_table[i*NO +: NO]) first = i;
    seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (res_wr_a) begin
        checks++;
        if (mm_a !== (int'(res_addr_a) >= first) || (mm_a && fi_a !== 3'(first))) begin
          errors++;
          $display("FAIL check addr %0d: got mismatch %b idx %0d want %b idx %0d",
                   res_addr_a, mm_a, fi_a, int'(res_addr_a) >= first, first);
        end
      end
      if (done_a) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 1 || mm_a !== 1'b1 || fi_a !== 3'(first)) begin
      errors++;
      $display("FAIL check sticky: got done %0d mismatch %b idx %0d want 1 1 %0d", seen, mm_a, fi_a, first);
    end
    load_named_eval(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mm_a !== 1'b0 || fi_a !== '0) begin
      errors++;
      $display("FAIL check clear on start: got %b %0d want 0 0", mm_a, fi_a);
    end
    for (int c = 0; c < 50; c++) @(negedge clk);
    checks++;
    if (mm_a !== 1'b0) begin
      errors++;
      $display("FAIL check clean sweep: got mismatch %b want 0", mm_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_named_eval();
    test_random_eval();
    test_start_ignored();
    load_named_eval(1'b0);
    test_stop("stop_v3", 3, 1'b0);
    load_random_eval();
    test_stop("stop_rand", $urandom_range(1, 7), 1'($urandom_range(0, 1)));
    test_stop_start_same_cycle();
    test_async_reset();
`ifdef LOGIC_SWEEP_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
